// File: rtl/pre_if_fetch_pkg.sv
// rtl/pre_if_fetch_pkg.sv - shared widths, FSM encodings and redirect priorities for the pre-IF stage
package pre_if_fetch_pkg;

    localparam int          BR_BUS_WD        = 34;
    localparam int          PS_TO_FS_BUS_WD  = 65;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic [1:0] {
        PS_REQ  = 2'd0,
        PS_WAIT = 2'd1,
        PS_HOLD = 2'd2
    } ps_state_e;

    // Ordered so that a numerically larger value wins the merge.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_ERET = 2'd2,
        RD_EX   = 2'd3
    } rd_prio_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ps_redirect_buf.sv
// rtl/ps_redirect_buf.sv - single-entry redirect buffer merging ws_ex > eret > br_taken
module ps_redirect_buf
    import pre_if_fetch_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_ex,
    input  logic        eret,
    input  logic [31:0] cp0_epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        consume,
    output logic        rd_valid,
    output logic        rd_flush,
    output logic [31:0] rd_target
);

    rd_prio_e    buf_prio;
    rd_prio_e    in_prio;
    rd_prio_e    win_prio;
    logic [31:0] buf_target;
    logic [31:0] in_target;
    logic [31:0] win_target;

    always_comb begin
        in_prio   = RD_NONE;
        in_target = 32'd0;
        if (ws_ex) begin
            in_prio   = RD_EX;
            in_target = EX_ENTRY;
        end else if (eret) begin
            in_prio   = RD_ERET;
            in_target = cp0_epc;
        end else if (br_taken) begin
            in_prio   = RD_BR;
            in_target = br_target;
        end
    end

    // A fresh redirect of equal or higher priority replaces the buffered one.
    always_comb begin
        win_prio   = buf_prio;
        win_target = buf_target;
        if (in_prio != RD_NONE && in_prio >= buf_prio) begin
            win_prio   = in_prio;
            win_target = in_target;
        end
    end

    assign rd_valid  = (win_prio != RD_NONE);
    assign rd_flush  = (win_prio == RD_EX) || (win_prio == RD_ERET);
    assign rd_target = win_target;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_prio   <= RD_NONE;
            buf_target <= 32'd0;
        end else if (consume) begin
            buf_prio   <= RD_NONE;
            buf_target <= 32'd0;
        end else if (win_prio != RD_NONE) begin
            buf_prio   <= win_prio;
            buf_target <= win_target;
        end
    end

endmodule

// File: rtl/pre_if_fetch.sv
// rtl/pre_if_fetch.sv - pre-IF fetch PC owner and instruction bus master; optional PS_PERF_CNT_EN adds perf counters
module pre_if_fetch
    import pre_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fs_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       ws_ex,
    input  logic                       eret,
    input  logic [31:0]                cp0_epc,
    output logic                       ps_to_fs_valid,
    output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
`ifdef PS_PERF_CNT_EN
    ,
    output logic [31:0]                perf_req_cnt,
    output logic [31:0]                perf_drop_cnt
`endif
);

    ps_state_e   state;
    ps_state_e   state_next;
    logic [31:0] pc;
    logic        adel;
    logic [31:0] inst;
    logic        discard;

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        rd_valid;
    logic        rd_flush;
    logic [31:0] rd_target;
    logic        consume;
    logic        pc_unaligned;
    logic        req_fire;
    logic        resp;
    logic        resp_keep;

    assign {br_stall, br_taken, br_target} = br_bus;

    assign pc_unaligned = |pc[1:0];
    assign req_fire     = inst_sram_req && inst_sram_addr_ok;
    assign resp         = (state == PS_WAIT) && inst_sram_data_ok;
    assign resp_keep    = resp && !discard && !rd_valid;

    ps_redirect_buf #(
        .EX_ENTRY (EX_ENTRY)
    ) u_redirect_buf (
        .clk       (clk),
        .resetn    (resetn),
        .ws_ex     (ws_ex),
        .eret      (eret),
        .cp0_epc   (cp0_epc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .consume   (consume),
        .rd_valid  (rd_valid),
        .rd_flush  (rd_flush),
        .rd_target (rd_target)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= PS_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        consume    = 1'b0;
        case (state)
            PS_REQ: begin
                consume = rd_valid;
                if (req_fire) begin
                    state_next = PS_WAIT;
                end else if (!rd_valid && pc_unaligned) begin
                    state_next = PS_HOLD;
                end
            end
            PS_WAIT: begin
                consume = rd_valid;
                if (inst_sram_data_ok) begin
                    state_next = (discard || rd_valid) ? PS_REQ : PS_HOLD;
                end
            end
            PS_HOLD: begin
                // A buffered branch waits here for the delay slot to be handed off.
                consume = rd_valid && (rd_flush || fs_allowin);
                if (rd_flush || fs_allowin) begin
                    state_next = PS_REQ;
                end
            end
            default: state_next = PS_REQ;
        endcase
    end

    always_comb begin
        inst_sram_req  = 1'b0;
        ps_to_fs_valid = 1'b0;
        case (state)
            PS_REQ:  inst_sram_req  = resetn && !br_stall && !pc_unaligned;
            PS_HOLD: ps_to_fs_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc      <= RESET_PC;
            adel    <= 1'b0;
            inst    <= 32'd0;
            discard <= 1'b0;
        end else begin
            case (state)
                PS_REQ: begin
                    if (rd_valid) begin
                        pc <= rd_target;
                        if (req_fire) begin
                            discard <= 1'b1;
                        end
                    end else if (pc_unaligned) begin
                        adel <= 1'b1;
                        inst <= 32'd0;
                    end
                end
                PS_WAIT: begin
                    if (rd_valid) begin
                        pc <= rd_target;
                    end
                    if (inst_sram_data_ok) begin
                        discard <= 1'b0;
                    end else if (rd_valid) begin
                        discard <= 1'b1;
                    end
                    if (resp_keep) begin
                        adel <= 1'b0;
                        inst <= inst_sram_rdata;
                    end
                end
                PS_HOLD: begin
                    if (rd_flush) begin
                        pc <= rd_target;
                    end else if (fs_allowin) begin
                        pc <= rd_valid ? rd_target : pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ps_to_fs_bus    = ps_to_fs_valid ? {adel, inst, pc} : {PS_TO_FS_BUS_WD{1'b0}};
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_addr  = align_word(pc);
    assign inst_sram_wdata = 32'd0;

`ifdef PS_PERF_CNT_EN
    logic resp_drop;
    assign resp_drop = resp && (discard || rd_valid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_req_cnt  <= 32'd0;
            perf_drop_cnt <= 32'd0;
        end else begin
            if (req_fire) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (resp_drop) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_pre_if_fetch.sv
// tb/tb_pre_if_fetch.sv - table-driven bench for pre_if_fetch
module tb_pre_if_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fs_allowin = 1'b0;
    logic [33:0] br_bus = '0;
    logic        ws_ex = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        ps_to_fs_valid;
    logic [64:0] ps_to_fs_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
`ifdef PS_PERF_CNT_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    pre_if_fetch dut (
        .clk               (clk),
        .resetn            (resetn),
        .fs_allowin        (fs_allowin),
        .br_bus            (br_bus),
        .ws_ex             (ws_ex),
        .eret              (eret),
        .cp0_epc           (cp0_epc),
        .ps_to_fs_valid    (ps_to_fs_valid),
        .ps_to_fs_bus      (ps_to_fs_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
`ifdef PS_PERF_CNT_EN
        ,
        .perf_req_cnt      (perf_req_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    typedef struct {
        logic        allow, stall, brt, ex, er, aok, dok;
        logic [31:0] rdata, tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid, eadel;
        logic [31:0] einst, epc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic allow, stall, brt, ex, er, aok, dok,
                       input logic [31:0] rdata, tgt,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, eadel, input logic [31:0] einst, epc);
        vec_t t;
        t.allow = allow; t.stall = stall; t.brt = brt; t.ex = ex; t.er = er;
        t.aok = aok; t.dok = dok; t.rdata = rdata; t.tgt = tgt;
        t.ereq = ereq; t.eaddr = eaddr; t.evalid = evalid; t.eadel = eadel;
        t.einst = einst; t.epc = epc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        fs_allowin        = t.allow;
        br_bus            = {t.stall, t.brt, t.tgt};
        ws_ex             = t.ex;
        eret              = t.er;
        cp0_epc           = t.tgt;
        inst_sram_addr_ok = t.aok;
        inst_sram_data_ok = t.dok;
        inst_sram_rdata   = t.rdata;
    endtask

    initial begin
        vec_t  zero;
        logic [64:0] exp_bus;

        //  al st bt ex er ao do  rdata         tgt           rq addr          vl ad inst          pc
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h24010001, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h24010001, 32'hbfc00000);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00004, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h11111111, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h11111111, 32'hbfc00004);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00008, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'hdeadbeef, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00380, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h22222222, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h22222222, 32'hbfc00380);
        add(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hbfc00010, 1, 32'hbfc00384, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00010, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h33333333, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'hbfc00100, 0, 32'h0,        1, 0, 32'h33333333, 32'hbfc00010);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h33333333, 32'hbfc00010);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h33333333, 32'hbfc00010);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h33333333, 32'hbfc00010);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00100, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h44444444, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h44444444, 32'hbfc00100);
        add(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hbfc00202, 1, 32'hbfc00104, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h0,        32'hbfc00202);
        add(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h0,        32'hbfc00202);
        for (int k = 0; k < 4; k++)
            add(0, 1, 0, 0, 0, 1, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hbfc00380, 0, 0, 32'h0,        32'h0);
        add(0, 0, 1, 0, 0, 1, 0, 32'h0,        32'hbfc00500, 1, 32'hbfc00380, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h55555555, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00500, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 1, 0, 0, 1, 32'haaaaaaaa, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hbfc00380, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hbfc00380, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h66666666, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h66666666, 32'hbfc00380);
        add(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hfffffffc, 1, 32'hbfc00384, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'hfffffffc, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h77777777, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h77777777, 32'hfffffffc);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00000000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 32'h00000000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h88888888, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h88888888, 32'h00000000);

        zero = vecs[$];
        zero.allow = 1'b0;

        #12;
        chk("reset_req", {64'd0, inst_sram_req}, 65'd0);
        chk("reset_valid", {64'd0, ps_to_fs_valid}, 65'd0);
        chk("reset_bus", ps_to_fs_bus, 65'd0);
        chk("tied_outputs", {31'd0, inst_sram_wr, inst_sram_size, inst_sram_wdata},
            {31'd0, 1'b0, 2'd2, 32'd0});

        @(posedge clk); #2;
        resetn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #1;
            exp_bus = vecs[i].evalid ? {vecs[i].eadel, vecs[i].einst, vecs[i].epc} : 65'd0;
            chk($sformatf("row%0d_req", i), {64'd0, inst_sram_req}, {64'd0, vecs[i].ereq});
            if (vecs[i].ereq)
                chk($sformatf("row%0d_addr", i), {33'd0, inst_sram_addr}, {33'd0, vecs[i].eaddr});
            chk($sformatf("row%0d_valid", i), {64'd0, ps_to_fs_valid}, {64'd0, vecs[i].evalid});
            chk($sformatf("row%0d_bus", i), ps_to_fs_bus, exp_bus);
            @(posedge clk); #2;
        end

        // Still in HOLD on pc 0; pull reset mid-cycle with a late data_ok present.
        zero.aok = 1'b0; zero.dok = 1'b0; zero.rdata = 32'h0;
        apply(zero);
        #1;
        chk("hold_before_reset", {64'd0, ps_to_fs_valid}, 65'd1);
        resetn = 1'b0;
        inst_sram_data_ok = 1'b1;
        #1;
        chk("async_reset_valid", {64'd0, ps_to_fs_valid}, 65'd0);
        chk("async_reset_bus", ps_to_fs_bus, 65'd0);
        chk("async_reset_req", {64'd0, inst_sram_req}, 65'd0);
        @(posedge clk); #2;
        chk("reset_late_data_valid", {64'd0, ps_to_fs_valid}, 65'd0);
        @(posedge clk); #2;
        inst_sram_data_ok = 1'b0;
        resetn = 1'b1;
        #1;
        chk("post_reset_req", {64'd0, inst_sram_req}, 65'd1);
        chk("post_reset_addr", {33'd0, inst_sram_addr}, {33'd0, 32'hbfc00000});
        inst_sram_addr_ok = 1'b1;
        @(posedge clk); #2;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h99999999;
        #1;
        chk("post_reset_wait_req", {64'd0, inst_sram_req}, 65'd0);
        @(posedge clk); #2;
        inst_sram_data_ok = 1'b0;
        #1;
        chk("post_reset_handoff", ps_to_fs_bus, {1'b0, 32'h99999999, 32'hbfc00000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
